rlc_step_ctrl: RTL
==================

Name: rlc_step_ctrl

Overview:
Step-response sequencer for the fixed-point RLC model.
- Resets the model, holds the input at a low level, then applies a step to the high level.
- Monitors the model output until it settles inside a tolerance band or a cycle budget expires.
- Reports settle time and, optionally, overshoot.
- Sits beside the model instance and drives its fixed-point input, reset and sampled output.

Parameters:
WIDTH, 18, fixed-point word width of v_in/v_out (signed, shared exponent handled outside)
CNT_W, 16, width of cycle counters and time results
RST_CYCLES, 4, cycles model_rst is held during the RESET_MODEL state (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin a run; sampled only in IDLE
step_lo  input  WIDTH  signed pre-step level
step_hi  input  WIDTH  signed post-step level
tol  input  WIDTH  unsigned settle band half-width
hold_cycles  input  CNT_W  consecutive in-band cycles required; 0 treated as 1
max_cycles  input  CNT_W  STEP-cycle budget; 0 treated as 1
v_out_in  input  WIDTH  signed model output
v_in_out  output  WIDTH  signed model input
model_rst  output  1  model reset
busy  output  1  high outside IDLE
done  output  1  one-cycle completion pulse
settled  output  1  last run settled (held until next start)
timeout  output  1  last run hit budget (held until next start)
settle_cycles  output  CNT_W  STEP index where the qualifying in-band run began, or max_cycles on timeout
overshoot  output  WIDTH  unsigned peak excursion beyond step_hi

Behaviour:
- Clock and reset: all state registered on clk. Reset values: v_in_out=0, model_rst=0, busy=0, done=0, settled=0, timeout=0, settle_cycles=0, overshoot=0; state=IDLE.
- Reset mid-run: the run aborts on that edge and no done pulse is produced.
- IDLE: v_in_out=0.
  - start=1 latches step_lo, step_hi, tol, hold_cycles, max_cycles.
  - It also clears settled, timeout, settle_cycles and overshoot, then moves to RESET_MODEL.
- RESET_MODEL: model_rst=1, v_in_out=step_lo for RST_CYCLES cycles, then PRE.
- PRE: model_rst=0, v_in_out=step_lo for exactly hold_cycles cycles, then STEP.
- STEP: v_in_out=step_hi from the first STEP cycle (index k=0).
  - Each cycle samples v_out_in with index k.
  - err = v_out_in - step_hi, computed at WIDTH+1 bits; |err| compared against zero-extended tol; in-band when |err| <= tol. tol=0 requires exact equality.
  - Run counter resets to 0 on any out-of-band sample. The run start index is captured on the first in-band sample after an out-of-band sample or after STEP entry.
  - When the run counter reaches hold_cycles: settled=1, settle_cycles=run start index, go to DONE.
  - Otherwise, after sample k=max_cycles-1: timeout=1, settle_cycles=max_cycles, go to DONE.
  - If settle and timeout occur on the same sample, settle wins.
- DONE: done=1 for one cycle, v_in_out=step_hi, then IDLE.
  - Latency: done is asserted one cycle after the decisive sample.
- start outside IDLE is ignored.
- Counters saturate; they never wrap.

Optional Feature:
- RLC_STEP_CTRL_PEAK_EN defined: during STEP, tracks the peak excursion in the step direction.
  - Rising step (step_hi>=step_lo): overshoot = max(0, max(v_out_in) - step_hi).
  - Falling step: overshoot = max(0, step_hi - min(v_out_in)).
  - Result saturates to the WIDTH unsigned maximum.
- Undefined: overshoot tied to 0 and the peak logic is absent.

Decomposition:
- Package rlc_ctrl_pkg: state enum (IDLE, RESET_MODEL, PRE, STEP, DONE), the abs/saturate helper function, and the RST_CYCLES default constant.
- Sub-module rlc_settle_det: band comparator, run counter and run-start capture. Inputs: clear, sample, k, step_hi, tol, hold. Outputs: settled pulse and start index.

Test Plan (WIDTH=18, CNT_W=16, RST_CYCLES=4; bench drives v_out_in directly):
- Reset: rst high 2 cycles mid-STEP -> next cycle busy=0, v_in_out=0, model_rst=0, done never pulses.
- Settle: step 0->1000, tol=10, hold=4, max=100; v_out_in=0 for k<3, 995 from k=3 -> settled=1, settle_cycles=3, done in cycle after k=6.
- Broken run: same setup, v_out_in in-band at k=2,3, 1020 at k=4, 1005 from k=5 -> settle_cycles=5, done after k=8.
- Timeout: v_out_in stuck at 0, max=20 -> timeout=1, settled=0, settle_cycles=20, done after k=19.
- Sequencing and edge inputs: check model_rst high exactly 4 cycles, then PRE holds v_in_out=step_lo for hold_cycles cycles. With hold=0, tol=0 and v_out_in=1000 at k=0 -> settled, settle_cycles=0.
- PEAK_EN: step 0->1000, v_out_in 1200 at k=2, then 1000 -> overshoot=200. Falling step 1000->0 with minimum -150 -> overshoot=150. Without the macro -> overshoot=0.

Source files
------------

// File: rtl/rlc_step_ctrl_pkg.sv
// Shared definitions for the RLC step-response sequencer: state encoding,
// default model-reset length and the abs/saturate helpers.
package rlc_ctrl_pkg;

    localparam int RST_CYCLES_DEFAULT = 4;

    typedef logic [2:0] state_t;

    localparam state_t IDLE        = 3'd0;
    localparam state_t RESET_MODEL = 3'd1;
    localparam state_t PRE         = 3'd2;
    localparam state_t STEP        = 3'd3;
    localparam state_t DONE        = 3'd4;

    // Callers sign-extend narrower words into 64 bits, so one helper serves any WIDTH.
    function automatic logic [63:0] abs_s64(input logic signed [63:0] x);
        return (x < 0) ? 64'(-x) : 64'(x);
    endfunction

    function automatic logic [63:0] sat_u64(input logic [63:0] x, input int unsigned w);
        logic [63:0] lim;
        lim = (64'd1 << w) - 64'd1;
        return (x > lim) ? lim : x;
    endfunction

endpackage

// File: rtl/rlc_step_ctrl_settle_det.sv
// Settle detector: tolerance-band comparator, consecutive in-band run counter
// and capture of the STEP index where the current run began.
module rlc_settle_det
    import rlc_ctrl_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    sample_en,
    input  logic signed [WIDTH-1:0] sample,
    input  logic [CNT_W-1:0]        k,
    input  logic signed [WIDTH-1:0] step_hi,
    input  logic [WIDTH-1:0]        tol,
    input  logic [CNT_W-1:0]        hold,
    output logic                    settled,
    output logic [CNT_W-1:0]        start_idx
);

    localparam int EW = WIDTH + 1;

    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_start;
    logic [CNT_W-1:0] run_next;
    logic [EW-1:0]    err;
    logic [EW-1:0]    err_mag;
    logic             in_band;

    // Error is formed one bit wider so full-range operands cannot overflow.
    always_comb begin
        err       = {sample[WIDTH-1], sample} - {step_hi[WIDTH-1], step_hi};
        err_mag   = EW'(abs_s64({{(64-EW){err[EW-1]}}, err}));
        in_band   = (err_mag <= {1'b0, tol});
        run_next  = '0;
        if (in_band)
            run_next = (run_cnt == '1) ? run_cnt : run_cnt + CNT_W'(1);
        settled   = sample_en && in_band && (run_next >= hold);
        start_idx = (run_cnt == '0) ? k : run_start;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_cnt   <= '0;
            run_start <= '0;
        end else if (sample_en) begin
            run_cnt <= run_next;
            if (in_band && run_cnt == '0)
                run_start <= k;
        end
    end

endmodule

// File: rtl/rlc_step_ctrl.sv
// Step-response sequencer for the fixed-point RLC model. Define
// RLC_STEP_CTRL_PEAK_EN to build the overshoot (peak excursion) tracker.
module rlc_step_ctrl
    import rlc_ctrl_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = RST_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] step_lo,
    input  logic signed [WIDTH-1:0] step_hi,
    input  logic [WIDTH-1:0]        tol,
    input  logic [CNT_W-1:0]        hold_cycles,
    input  logic [CNT_W-1:0]        max_cycles,
    input  logic signed [WIDTH-1:0] v_out_in,
    output logic signed [WIDTH-1:0] v_in_out,
    output logic                    model_rst,
    output logic                    busy,
    output logic                    done,
    output logic                    settled,
    output logic                    timeout,
    output logic [CNT_W-1:0]        settle_cycles,
    output logic [WIDTH-1:0]        overshoot
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        k;
    logic signed [WIDTH-1:0] lo_q;
    logic signed [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0]        tol_q;
    logic [CNT_W-1:0]        hold_q;
    logic [CNT_W-1:0]        max_q;
    logic                    det_settled;
    logic [CNT_W-1:0]        det_start;

    rlc_settle_det #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_det (
        .clk      (clk),
        .rst      (rst),
        .clear    (state != STEP),
        .sample_en(state == STEP),
        .sample   (v_out_in),
        .k        (k),
        .step_hi  (hi_q),
        .tol      (tol_q),
        .hold     (hold_q),
        .settled  (det_settled),
        .start_idx(det_start)
    );

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        model_rst = (state == RESET_MODEL);
        case (state)
            RESET_MODEL, PRE: v_in_out = lo_q;
            STEP, DONE:       v_in_out = hi_q;
            default:          v_in_out = '0;
        endcase
    end

    // Zero hold/budget values are promoted to 1 at latch time so the FSM never sees them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            k             <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            tol_q         <= '0;
            hold_q        <= '0;
            max_q         <= '0;
            settled       <= 1'b0;
            timeout       <= 1'b0;
            settle_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lo_q          <= step_lo;
                        hi_q          <= step_hi;
                        tol_q         <= tol;
                        hold_q        <= (hold_cycles == '0) ? CNT_W'(1) : hold_cycles;
                        max_q         <= (max_cycles == '0) ? CNT_W'(1) : max_cycles;
                        settled       <= 1'b0;
                        timeout       <= 1'b0;
                        settle_cycles <= '0;
                        cnt           <= '0;
                        state         <= RESET_MODEL;
                    end
                end
                RESET_MODEL: begin
                    if (cnt == RST_LAST) begin
                        cnt   <= '0;
                        state <= PRE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRE: begin
                    if (cnt == hold_q - CNT_W'(1)) begin
                        cnt   <= '0;
                        k     <= '0;
                        state <= STEP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STEP: begin
                    if (det_settled) begin
                        settled       <= 1'b1;
                        settle_cycles <= det_start;
                        state         <= DONE;
                    end else if (k == max_q - CNT_W'(1)) begin
                        timeout       <= 1'b1;
                        settle_cycles <= max_q;
                        state         <= DONE;
                    end else if (k != '1) begin
                        k <= k + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RLC_STEP_CTRL_PEAK_EN
    logic              rising;
    logic [WIDTH:0]    exc;
    logic [WIDTH-1:0]  exc_sat;

    // Excursion is measured past step_hi in the direction of the step.
    always_comb begin
        rising  = (hi_q >= lo_q);
        exc     = rising ? ({v_out_in[WIDTH-1], v_out_in} - {hi_q[WIDTH-1], hi_q})
                         : ({hi_q[WIDTH-1], hi_q} - {v_out_in[WIDTH-1], v_out_in});
        exc_sat = WIDTH'(sat_u64({{(63-WIDTH){1'b0}}, exc}, WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overshoot <= '0;
        end else if (state == IDLE && start) begin
            overshoot <= '0;
        end else if (state == STEP && !exc[WIDTH] && exc != '0 && exc_sat > overshoot) begin
            overshoot <= exc_sat;
        end
    end
`else
    assign overshoot = '0;
`endif

endmodule
